// File: rtl/nth_root_pkg.sv
// rtl/nth_root_pkg.sv - shared state encoding and width helpers for the n-th root unit
package nth_root_pkg;

  localparam int DEF_DATA_W = 10;
  localparam int DEF_FRAC_W = 10;
  localparam int DEF_EXP_W  = 3;
  localparam int DEF_RES_W  = DEF_DATA_W + DEF_FRAC_W;
  localparam int DEF_PROD_W = 2 * DEF_RES_W;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    MUL  = 3'd2,
    CMP  = 3'd3,
    DONE = 3'd4
  } state_t;

  function automatic int res_w(input int data_w, input int frac_w);
    return data_w + frac_w;
  endfunction

  function automatic int prod_w(input int data_w, input int frac_w);
    return 2 * (data_w + frac_w);
  endfunction

endpackage

// File: rtl/nth_root_fxmul.sv
// rtl/nth_root_fxmul.sv - combinational Q(DATA_W).(FRAC_W) multiply with truncation and saturation
module nth_root_fxmul
  import nth_root_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int FRAC_W = DEF_FRAC_W
) (
  input  logic [DATA_W+FRAC_W-1:0] a,
  input  logic [DATA_W+FRAC_W-1:0] b,
  output logic [DATA_W+FRAC_W-1:0] p,
  output logic                     ovf
);

  localparam int RES_W  = res_w(DATA_W, FRAC_W);
  localparam int PROD_W = prod_w(DATA_W, FRAC_W);

  logic [PROD_W-1:0] prod;
  logic [DATA_W-1:0] hi;

  assign prod = {{RES_W{1'b0}}, a} * {{RES_W{1'b0}}, b};
  // Bits above the Q-format window after the FRAC_W shift mean the value no longer fits.
  assign hi   = prod[PROD_W-1 -: DATA_W];
  assign ovf  = |hi;
  assign p    = ovf ? {RES_W{1'b1}} : prod[FRAC_W +: RES_W];

endmodule

// File: rtl/nth_root_seq.sv
// rtl/nth_root_seq.sv - bit-serial fixed-point n-th root; NTH_ROOT_EXACT_EXIT_EN enables early exit on exact hit
module nth_root_seq
  import nth_root_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int FRAC_W = DEF_FRAC_W,
  parameter int EXP_W  = DEF_EXP_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_radicand,
  input  logic [EXP_W-1:0]         in_exp,
  output logic                     out_valid,
  output logic [DATA_W+FRAC_W-1:0] out_data,
  output logic                     out_exact,
  output logic                     out_err
);

  localparam int RES_W = res_w(DATA_W, FRAC_W);

`ifdef NTH_ROOT_EXACT_EXIT_EN
  localparam bit EARLY_EXIT = 1'b1;
`else
  localparam bit EARLY_EXIT = 1'b0;
`endif

  state_t state, state_next;

  logic [RES_W-1:0] target;
  logic [EXP_W-1:0] n;
  logic [RES_W-1:0] guess;
  logic [RES_W-1:0] bitp;
  logic [RES_W-1:0] cand;
  logic [RES_W-1:0] acc;
  logic [EXP_W-1:0] cnt;
  logic             ovf;
  logic             exact;
  logic             err;

  logic             accept;
  logic [RES_W-1:0] target_in;
  logic [EXP_W-1:0] cnt_next;
  logic [RES_W-1:0] mul_p;
  logic             mul_ovf;
  logic             cmp_take;
  logic             cmp_exact;

  assign accept    = in_valid && in_ready;
  assign target_in = {in_radicand, {FRAC_W{1'b0}}};
  assign cnt_next  = cnt + 1'b1;
  assign cmp_take  = !ovf && (acc <= target);
  assign cmp_exact = !ovf && (acc == target);

  nth_root_fxmul #(
    .DATA_W(DATA_W),
    .FRAC_W(FRAC_W)
  ) u_fxmul (
    .a  (acc),
    .b  (cand),
    .p  (mul_p),
    .ovf(mul_ovf)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (accept) state_next = (in_exp < 2) ? DONE : LOAD;
      end
      LOAD: state_next = MUL;
      MUL: begin
        if (cnt_next == n) state_next = CMP;
      end
      CMP: begin
        if (bitp[0] || (EARLY_EXIT && cmp_exact)) state_next = DONE;
        else                                      state_next = LOAD;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE) && !rst;
    out_valid = (state == DONE);
    out_data  = out_valid ? guess : '0;
    out_exact = out_valid && exact;
    out_err   = out_valid && err;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      target <= '0;
      n      <= '0;
      guess  <= '0;
      bitp   <= '0;
      cand   <= '0;
      acc    <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
      exact  <= 1'b0;
      err    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            target <= target_in;
            n      <= in_exp;
            guess  <= (in_exp == 1) ? target_in : '0;
            exact  <= (in_exp == 1);
            err    <= (in_exp == 0);
            bitp   <= {1'b1, {(RES_W-1){1'b0}}};
          end
        end
        LOAD: begin
          cand <= guess | bitp;
          acc  <= guess | bitp;
          cnt  <= 1;
          ovf  <= 1'b0;
        end
        MUL: begin
          acc <= mul_p;
          ovf <= ovf | mul_ovf;
          cnt <= cnt_next;
        end
        CMP: begin
          // exact tracks the kept guess, so a rejected candidate leaves it alone
          if (cmp_take) begin
            guess <= cand;
            exact <= cmp_exact;
          end
          bitp <= bitp >> 1;
        end
        default: ;
      endcase
    end
  end

endmodule
